// File: rtl/booth_mult_pipe_if.sv
// Operand/product handshake bundle for booth_mult_pipe.
// rnd_o exists only when BOOTH_RND_EN is defined.
interface booth_mult_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned TAG_W  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     x_i;
  logic [DATA_W-1:0]     y_i;
  logic [TAG_W-1:0]      tag_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   prod_o;
  logic [TAG_W-1:0]      tag_o;
`ifdef BOOTH_RND_EN
  logic [DATA_W-1:0]     rnd_o;
`endif

  modport master (
    output in_valid, x_i, y_i, tag_i, out_ready,
    input  in_ready, out_valid, prod_o, tag_o
`ifdef BOOTH_RND_EN
    , rnd_o
`endif
  );

  modport slave (
    input  in_valid, x_i, y_i, tag_i, out_ready,
    output in_ready, out_valid, prod_o, tag_o
`ifdef BOOTH_RND_EN
    , rnd_o
`endif
  );
endinterface

// File: rtl/booth_mult_pipe.sv
// Pipelined signed radix-4 Booth multiplier with registered adder tree and valid/ready stall.
// Define BOOTH_RND_EN to add the rounded/saturated rnd_o output and one extra stage.
module booth_mult_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_mult_pipe_if.slave   io
);
  localparam int unsigned PW  = 2 * DATA_W;
  localparam int unsigned NPP = DATA_W / 2;
  localparam int unsigned L   = $clog2(NPP);

  function automatic int unsigned cnt(input int unsigned k);
    return (NPP + (1 << k) - 1) >> k;
  endfunction

  logic                w_stall;
  logic                w_out_valid;
  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;
  logic                r_v   [L+2];
  logic [TAG_W-1:0]    r_tag [L+2];

  assign w_stall     = w_out_valid & ~io.out_ready;
  assign io.in_ready = ~w_stall;

  // valid/tag shift register: index 0 is the input stage, L+1 the tree root
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      for (int unsigned i = 0; i < L + 2; i++) begin
        r_v[i]   <= 1'b0;
        r_tag[i] <= '0;
      end
    end else if (!w_stall) begin
      r_x      <= io.x_i;
      r_y      <= io.y_i;
      r_v[0]   <= io.in_valid;
      r_tag[0] <= io.tag_i;
      for (int unsigned i = 1; i < L + 2; i++) begin
        r_v[i]   <= r_v[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  logic [DATA_W:0]     w_yx;
  logic [PW-1:0]       w_xe;
  logic [2:0]          w_grp;
  logic [PW-1:0]       w_mag;
  logic                w_neg;
  logic [PW-1:0]       w_pp [NPP];

  always_comb begin
    w_yx  = {r_y, 1'b0};
    w_xe  = {{DATA_W{r_x[DATA_W-1]}}, r_x};
    w_grp = '0;
    w_mag = '0;
    w_neg = 1'b0;
    for (int unsigned j = 0; j < NPP; j++) begin
      w_grp = w_yx[2*j +: 3];
      case (w_grp)
        3'b001, 3'b010: begin w_mag = w_xe;      w_neg = 1'b0; end
        3'b011:         begin w_mag = w_xe << 1; w_neg = 1'b0; end
        3'b100:         begin w_mag = w_xe << 1; w_neg = 1'b1; end
        3'b101, 3'b110: begin w_mag = w_xe;      w_neg = 1'b1; end
        default:        begin w_mag = '0;        w_neg = 1'b0; end
      endcase
      // ones' complement term plus the +1 correction at weight 2^(2j)
      w_pp[j] = ((w_neg ? ~w_mag : w_mag) << (2 * j))
              + ({{(PW-1){1'b0}}, w_neg} << (2 * j));
    end
  end

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    logic [PW-1:0] r_sum [cnt(k)];
    if (k == 0) begin : g_booth
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < NPP; i++) r_sum[i] <= '0;
        end else if (!w_stall) begin
          for (int unsigned i = 0; i < NPP; i++) r_sum[i] <= w_pp[i];
        end
      end
    end else begin : g_add
      localparam int unsigned N_IN = cnt(k - 1);
      for (genvar i = 0; i < cnt(k); i++) begin : g_node
        if (2 * i + 1 < N_IN) begin : g_pair
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_sum[i] <= '0;
            else if (!w_stall) r_sum[i] <= g_lvl[k-1].r_sum[2*i] + g_lvl[k-1].r_sum[2*i+1];
          end
        end else begin : g_pass
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_sum[i] <= '0;
            else if (!w_stall) r_sum[i] <= g_lvl[k-1].r_sum[2*i];
          end
        end
      end
    end
  end

  logic [PW-1:0] w_prod;
  assign w_prod = g_lvl[L].r_sum[0];

`ifdef BOOTH_RND_EN
  localparam logic        [PW:0] RND_HALF = {{PW{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [PW:0] SAT_MAX  = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN  = {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PW:0]  w_biased;
  logic signed [PW:0]  w_shr;
  logic [DATA_W-1:0]   w_rnd;
  logic                r_v_q;
  logic [PW-1:0]       r_prod_q;
  logic [TAG_W-1:0]    r_tag_q;
  logic [DATA_W-1:0]   r_rnd;

  always_comb begin
    w_biased = $signed({w_prod[PW-1], w_prod}) + $signed(RND_HALF);
    w_shr    = w_biased >>> OUT_SHIFT;
    if (w_shr > SAT_MAX)      w_rnd = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_shr < SAT_MIN) w_rnd = {1'b1, {(DATA_W-1){1'b0}}};
    else                      w_rnd = w_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_q    <= 1'b0;
      r_prod_q <= '0;
      r_tag_q  <= '0;
      r_rnd    <= '0;
    end else if (!w_stall) begin
      r_v_q    <= r_v[L+1];
      r_prod_q <= w_prod;
      r_tag_q  <= r_tag[L+1];
      r_rnd    <= w_rnd;
    end
  end

  assign w_out_valid = r_v_q;
  assign io.prod_o   = r_prod_q;
  assign io.tag_o    = r_tag_q;
  assign io.rnd_o    = r_rnd;
`else
  assign w_out_valid = r_v[L+1];
  assign io.prod_o   = w_prod;
  assign io.tag_o    = r_tag[L+1];
`endif

  assign io.out_valid = w_out_valid;
endmodule

// File: tb/tb_booth_mult_pipe.sv
// Directed self-checking bench for booth_mult_pipe (default and BOOTH_RND_EN builds).
module tb_booth_mult_pipe;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned OUT_SHIFT = 15;
`ifdef BOOTH_RND_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int compared   = 0;
  int mismatched = 0;

  booth_mult_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) io ();
  booth_mult_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  // hand-computed products
  logic [15:0] vx [16] = '{16'h0003, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h0100, 16'hFF00,
                           16'h0064, 16'h8000, 16'h8000, 16'h5555, 16'hFFFE, 16'h1000, 16'h0007, 16'hFFFF};
  logic [15:0] vy [16] = '{16'hFFFB, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0100, 16'h0080,
                           16'hFF9C, 16'h0001, 16'h0002, 16'h0002, 16'hFFFD, 16'hF000, 16'h0009, 16'h7FFF};
  logic [31:0] vp [16] = '{32'hFFFF_FFF1, 32'h4000_0000, 32'hC000_8000, 32'h0000_0000,
                           32'h0000_0001, 32'h3FFF_0001, 32'h0001_0000, 32'hFFFF_8000,
                           32'hFFFF_D8F0, 32'hFFFF_8000, 32'hFFFF_0000, 32'h0000_AAAA,
                           32'h0000_0006, 32'hFF00_0000, 32'h0000_003F, 32'hFFFF_8001};

  task automatic test_reset();
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    io.x_i = '0; io.y_i = '0; io.tag_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (io.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", io.out_valid); end
    compared++; if (io.prod_o !== 32'h0) begin mismatched++; $display("FAIL reset_prod: got %h expected 0", io.prod_o); end
    compared++; if (io.tag_o !== 4'h0) begin mismatched++; $display("FAIL reset_tag: got %h expected 0", io.tag_o); end
    compared++; if (io.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", io.in_ready); end
`ifdef BOOTH_RND_EN
    compared++; if (io.rnd_o !== 16'h0) begin mismatched++; $display("FAIL reset_rnd: got %h expected 0", io.rnd_o); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int  lat = 0;
    bit  ir_bad = 0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.x_i = 16'h0003; io.y_i = 16'hFFFB; io.tag_i = 4'hA;
    for (int e = 1; e <= LAT + 3 && lat == 0; e++) begin
      @(posedge clk); #1;
      if (e == 1) io.in_valid = 1'b0;
      if (io.in_ready !== 1'b1) ir_bad = 1;
      if (io.out_valid === 1'b1) lat = e;
    end
    compared++; if (lat != LAT) begin mismatched++; $display("FAIL latency: got %0d expected %0d", lat, LAT); end
    compared++; if (io.prod_o !== 32'hFFFF_FFF1) begin mismatched++; $display("FAIL lat_prod: got %h expected fffffff1", io.prod_o); end
    compared++; if (io.tag_o !== 4'hA) begin mismatched++; $display("FAIL lat_tag: got %h expected a", io.tag_o); end
    compared++; if (ir_bad) begin mismatched++; $display("FAIL lat_in_ready: got 0 expected 1"); end
    @(posedge clk); #1;
    compared++; if (io.out_valid !== 1'b0) begin mismatched++; $display("FAIL lat_single: got out_valid %b expected 0", io.out_valid); end
  endtask

  task automatic test_corners();
    io.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      int lat = 0;
      @(posedge clk); #1;
      io.in_valid = 1'b1; io.x_i = vx[i]; io.y_i = vy[i]; io.tag_i = 4'(i);
      for (int e = 1; e <= LAT + 3 && lat == 0; e++) begin
        @(posedge clk); #1;
        if (e == 1) io.in_valid = 1'b0;
        if (io.out_valid === 1'b1) lat = e;
      end
      compared++;
      if (lat != LAT || io.prod_o !== vp[i] || io.tag_o !== 4'(i)) begin
        mismatched++;
        $display("FAIL corner_%0d: got lat %0d prod %h tag %h expected lat %0d prod %h tag %h",
                 i, lat, io.prod_o, io.tag_o, LAT, vp[i], 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 16 + 256;
    logic [15:0] sx [N];
    logic [15:0] sy [N];
    logic [31:0] sp [N];
    logic [31:0] expq [$];
    logic [3:0]  tagq [$];
    int sent = 0, got = 0;
    for (int i = 0; i < N; i++) begin
      if (i < 16) begin
        sx[i] = vx[i]; sy[i] = vy[i]; sp[i] = vp[i];
      end else begin
        sx[i] = 16'($urandom); sy[i] = 16'($urandom);
        sp[i] = $signed(sx[i]) * $signed(sy[i]);
      end
    end
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < N + LAT + 20 && got < N; cyc++) begin
      @(posedge clk); #1;
      if (sent < N) begin
        io.in_valid = 1'b1; io.x_i = sx[sent]; io.y_i = sy[sent]; io.tag_i = 4'(sent);
      end else io.in_valid = 1'b0;
      @(negedge clk);
      if (io.out_valid === 1'b1) begin
        compared++;
        if (expq.size() == 0) begin
          mismatched++; $display("FAIL b2b_extra: got tag %h expected no output", io.tag_o);
        end else begin
          logic [31:0] ep = expq.pop_front();
          logic [3:0]  et = tagq.pop_front();
          if (io.prod_o !== ep || io.tag_o !== et) begin
            mismatched++;
            $display("FAIL b2b_%0d: got prod %h tag %h expected prod %h tag %h", got, io.prod_o, io.tag_o, ep, et);
          end
        end
        got++;
      end else if (got > 0) begin
        compared++; mismatched++;
        $display("FAIL b2b_gap: got out_valid 0 expected 1 after %0d results", got);
      end
      if (io.in_valid && io.in_ready) begin
        expq.push_back(sp[sent]); tagq.push_back(4'(sent)); sent++;
      end
    end
    io.in_valid = 1'b0;
    compared++; if (got != N) begin mismatched++; $display("FAIL b2b_count: got %0d expected %0d", got, N); end
  endtask

  task automatic test_stall();
    logic [31:0] expq [$];
    logic [3:0]  tagq [$];
    logic [31:0] held_p = '0;
    logic [3:0]  held_t = '0;
    int sent = 0, got = 0, stall_left = 0;
    bit seen = 0, stalled = 0;
    io.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(posedge clk); #1;
      if (sent < 8) begin
        io.in_valid = 1'b1; io.x_i = vx[sent]; io.y_i = vy[sent]; io.tag_i = 4'(sent);
      end else io.in_valid = 1'b0;
      @(negedge clk);
      if (io.out_valid === 1'b1 && !seen) begin
        seen = 1; stalled = 1; stall_left = 4;
        io.out_ready = 1'b0; held_p = io.prod_o; held_t = io.tag_o;
      end
      if (stalled) begin
        if (stall_left == 0) begin
          stalled = 0; io.out_ready = 1'b1;
        end else begin
          #1;
          compared++; if (io.in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready: got %b expected 0", io.in_ready); end
          compared++;
          if (io.out_valid !== 1'b1 || io.prod_o !== held_p || io.tag_o !== held_t) begin
            mismatched++;
            $display("FAIL stall_hold: got v %b prod %h tag %h expected v 1 prod %h tag %h",
                     io.out_valid, io.prod_o, io.tag_o, held_p, held_t);
          end
          stall_left--;
        end
      end
      #1;
      if (io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
        compared++;
        if (expq.size() == 0) begin
          mismatched++; $display("FAIL stall_extra: got tag %h expected no output", io.tag_o);
        end else begin
          logic [31:0] ep = expq.pop_front();
          logic [3:0]  et = tagq.pop_front();
          if (io.prod_o !== ep || io.tag_o !== et) begin
            mismatched++;
            $display("FAIL stall_out_%0d: got prod %h tag %h expected prod %h tag %h", got, io.prod_o, io.tag_o, ep, et);
          end
        end
        got++;
      end
      if (io.in_valid && io.in_ready) begin
        expq.push_back(vp[sent]); tagq.push_back(4'(sent)); sent++;
      end
    end
    io.in_valid = 1'b0;
    compared++; if (got != 8 || !seen) begin mismatched++; $display("FAIL stall_count: got %0d expected 8", got); end
    repeat (LAT + 2) @(posedge clk);
    #1;
    compared++; if (io.out_valid !== 1'b0) begin mismatched++; $display("FAIL stall_dup: got out_valid %b expected 0", io.out_valid); end
  endtask

  task automatic test_reset_midstream();
    bit stray = 0;
    int lat = 0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      io.in_valid = 1'b1; io.x_i = vx[4+i]; io.y_i = vy[4+i]; io.tag_i = 4'(4+i);
    end
    compared++; if (io.out_valid !== 1'b1) begin mismatched++; $display("FAIL prereset_valid: got %b expected 1", io.out_valid); end
    #2;
    rst_n = 1'b0; io.in_valid = 1'b0;
    #1;
    compared++;
    if (io.out_valid !== 1'b0 || io.prod_o !== 32'h0 || io.tag_o !== 4'h0 || io.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL async_reset: got v %b prod %h tag %h rdy %b expected v 0 prod 0 tag 0 rdy 1",
               io.out_valid, io.prod_o, io.tag_o, io.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) stray = 1;
    end
    compared++; if (stray) begin mismatched++; $display("FAIL reset_flush: got out_valid 1 expected 0"); end
    @(posedge clk); #1;
    io.in_valid = 1'b1; io.x_i = 16'h7FFF; io.y_i = 16'h7FFF; io.tag_i = 4'h5;
    for (int e = 1; e <= LAT + 3 && lat == 0; e++) begin
      @(posedge clk); #1;
      if (e == 1) io.in_valid = 1'b0;
      if (io.out_valid === 1'b1) lat = e;
    end
    compared++;
    if (lat != LAT || io.prod_o !== 32'h3FFF_0001 || io.tag_o !== 4'h5) begin
      mismatched++;
      $display("FAIL post_reset: got lat %0d prod %h tag %h expected lat %0d prod 3fff0001 tag 5", lat, io.prod_o, io.tag_o, LAT);
    end
  endtask

`ifdef BOOTH_RND_EN
  task automatic test_rnd();
    logic [15:0] rx [4] = '{16'h0001, 16'h0001, 16'h8000, 16'h4000};
    logic [15:0] ry [4] = '{16'h4000, 16'h3FFF, 16'h8000, 16'h4000};
    logic [31:0] rp [4] = '{32'h0000_4000, 32'h0000_3FFF, 32'h4000_0000, 32'h1000_0000};
    logic [15:0] rr [4] = '{16'h0001, 16'h0000, 16'h7FFF, 16'h2000};
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int lat = 0;
      @(posedge clk); #1;
      io.in_valid = 1'b1; io.x_i = rx[i]; io.y_i = ry[i]; io.tag_i = 4'(i);
      for (int e = 1; e <= LAT + 3 && lat == 0; e++) begin
        @(posedge clk); #1;
        if (e == 1) io.in_valid = 1'b0;
        if (io.out_valid === 1'b1) lat = e;
      end
      compared++;
      if (lat != LAT || io.rnd_o !== rr[i] || io.prod_o !== rp[i]) begin
        mismatched++;
        $display("FAIL rnd_%0d: got lat %0d rnd %h prod %h expected lat %0d rnd %h prod %h",
                 i, lat, io.rnd_o, io.prod_o, LAT, rr[i], rp[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
`ifdef BOOTH_RND_EN
    test_rnd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
